// File: rtl/rgmii_rx_iddr_sequencer_if.sv
// rgmii_rx_iddr_sequencer_if: received byte stream with frame-boundary and error flags.
interface rgmii_rx_iddr_sequencer_if;
   logic       src_valid;
   logic [7:0] src_data;
   logic       src_first;
   logic       src_last;
   logic       src_error;
   modport master (output src_valid, src_data, src_first, src_last, src_error);
   modport slave  (input  src_valid, src_data, src_first, src_last, src_error);
endinterface

// File: rtl/rgmii_rx_iddr_sequencer.sv
// rgmii_rx_iddr_sequencer: RGMII RX IDDR reset/CE sequencing, byte assembly, preamble strip, frame stats.
// Optional in-band link status decode is built when RGMII_INBAND_STATUS_EN is defined.
module rgmii_rx_iddr_sequencer #(
   parameter int IDDR_RST_CYCLES = 8,
   parameter int MIN_PREAMBLE    = 2,
   parameter int MAX_PREAMBLE    = 15,
   parameter int MAX_FRAME_LEN   = 1522,
   parameter int CNT_W           = 16
) (
   input  logic                      C,
   input  logic                      R,
   output logic                      iddr_rst,
   output logic                      iddr_ce,
   input  logic [3:0]                rxd_q1,
   input  logic [3:0]                rxd_q2,
   input  logic                      ctl_q1,
   input  logic                      ctl_q2,
   rgmii_rx_iddr_sequencer_if.master src,
   output logic [CNT_W-1:0]          frames_ok,
   output logic [CNT_W-1:0]          frames_err,
   output logic                      link_up,
   output logic [1:0]                link_speed,
   output logic                      full_duplex
);
   localparam int TW = $clog2(IDDR_RST_CYCLES + 2);
   localparam int PW = $clog2(MAX_PREAMBLE + 2);
   localparam int LW = $clog2(MAX_FRAME_LEN + 2);
   typedef enum logic [2:0] {INIT, SETTLE, IDLE, PREAMBLE, DATA, DROP} state_e;
   state_e state_q, state_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [LW-1:0] len_q, len_d;
   logic [7:0] hold_q, hold_d, data_q, data_d;
   logic err_q, err_d, vld_q, vld_d, first_q, first_d, last_q, last_d, serr_q, serr_d;
   logic iddr_rst_q, iddr_rst_d, iddr_ce_q, iddr_ce_d;
   logic [CNT_W-1:0] ok_q, ok_d, bad_q, bad_d;
   logic [7:0] rx_byte;
   logic dv, er, is_pre, is_sfd, at_max, emit;
   assign rx_byte = {rxd_q2, rxd_q1};
   assign dv      = ctl_q1;
   assign er      = ctl_q1 ^ ctl_q2;
   assign is_pre  = dv && rx_byte == 8'h55;
   assign is_sfd  = dv && rx_byte == 8'hD5;
   assign at_max  = len_q == LW'(MAX_FRAME_LEN);
   // one byte is always held back so the final beat can carry src_last
   assign emit    = state_q == DATA && len_q != '0;
   always_ff @(posedge C or posedge R) begin
      if (R) begin
         state_q    <= INIT;
         tmr_q      <= '0;
         pre_q      <= '0;
         len_q      <= '0;
         hold_q     <= '0;
         err_q      <= 1'b0;
         vld_q      <= 1'b0;
         data_q     <= '0;
         first_q    <= 1'b0;
         last_q     <= 1'b0;
         serr_q     <= 1'b0;
         iddr_rst_q <= 1'b1;
         iddr_ce_q  <= 1'b0;
         ok_q       <= '0;
         bad_q      <= '0;
      end else begin
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         pre_q      <= pre_d;
         len_q      <= len_d;
         hold_q     <= hold_d;
         err_q      <= err_d;
         vld_q      <= vld_d;
         data_q     <= data_d;
         first_q    <= first_d;
         last_q     <= last_d;
         serr_q     <= serr_d;
         iddr_rst_q <= iddr_rst_d;
         iddr_ce_q  <= iddr_ce_d;
         ok_q       <= ok_d;
         bad_q      <= bad_d;
      end
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         INIT:     state_d = tmr_q == TW'(IDDR_RST_CYCLES - 1) ? SETTLE : INIT;
         SETTLE:   state_d = tmr_q == TW'(1) ? IDLE : SETTLE;
         IDLE:     state_d = !dv ? IDLE : is_pre ? PREAMBLE : DROP;
         PREAMBLE: state_d = is_pre ? (pre_q == PW'(MAX_PREAMBLE) ? DROP : PREAMBLE)
                           : is_sfd ? (pre_q >= PW'(MIN_PREAMBLE) ? DATA : DROP) : IDLE;
         DATA:     state_d = !dv ? IDLE : at_max ? DROP : DATA;
         DROP:     state_d = dv ? DROP : IDLE;
         default:  state_d = INIT;
      endcase
   end
   always_comb begin
      tmr_d      = ((state_q == INIT || state_q == SETTLE) && state_d == state_q) ? tmr_q + TW'(1) : '0;
      pre_d      = state_q == PREAMBLE ? pre_q + PW'(is_pre) : PW'(1);
      len_d      = (state_q == DATA && dv) ? len_q + LW'(1) : '0;
      hold_d     = (state_q == DATA && dv) ? rx_byte : hold_q;
      err_d      = state_q == DATA && (err_q || (dv && er));
      vld_d      = emit;
      data_d     = emit ? hold_q : '0;
      first_d    = emit && len_q == LW'(1);
      last_d     = emit && (!dv || at_max);
      serr_d     = last_d && (err_q || dv);
      ok_d       = (last_d && !serr_d && !(&ok_q)) ? ok_q + CNT_W'(1) : ok_q;
      bad_d      = (serr_d && !(&bad_q)) ? bad_q + CNT_W'(1) : bad_q;
      iddr_rst_d = state_d == INIT;
      iddr_ce_d  = state_d != INIT;
   end
   assign iddr_rst      = iddr_rst_q;
   assign iddr_ce       = iddr_ce_q;
   assign src.src_valid = vld_q;
   assign src.src_data  = data_q;
   assign src.src_first = first_q;
   assign src.src_last  = last_q;
   assign src.src_error = serr_q;
   assign frames_ok     = ok_q;
   assign frames_err    = bad_q;
`ifdef RGMII_INBAND_STATUS_EN
   logic [3:0] stat_q;
   always_ff @(posedge C or posedge R) begin
      if (R) stat_q <= '0;
      else if (state_q == IDLE && !ctl_q1 && !ctl_q2) stat_q <= rxd_q1;
   end
   assign link_up     = stat_q[0];
   assign link_speed  = stat_q[2:1];
   assign full_duplex = stat_q[3];
`else
   assign link_up     = 1'b0;
   assign link_speed  = 2'b00;
   assign full_duplex = 1'b0;
`endif
endmodule

// File: doc/rgmii_rx_iddr_sequencer.md
Name: rgmii_rx_iddr_sequencer

Overview:
Controller for the four data IDDRs and one control IDDR on the RGMII receive path, all running in SAME_EDGE_PIPELINED mode. After reset it holds the IDDRs in reset, then gates their CE. It assembles the Q1/Q2 nibble pairs into bytes, strips preamble and SFD, and emits a byte stream carrying frame-boundary and error flags. It also keeps saturating good/bad frame counters for the MAC CSR block.

Parameters:
IDDR_RST_CYCLES, 8, cycles iddr_rst stays high after R deasserts (range 1-255).
MIN_PREAMBLE, 2, minimum count of 0x55 bytes required before SFD.
MAX_PREAMBLE, 15, count of 0x55 bytes beyond which the preamble is rejected.
MAX_FRAME_LEN, 1522, payload bytes after SFD. A frame is truncated with error when its length exceeds this.
CNT_W, 16, width of the statistics counters.

Ports:
C  input  1  RX clock (RGMII rx_clk, same net as IDDR C).
R  input  1  asynchronous active-high reset.
iddr_rst  output  1  drives R of all IDDRs.
iddr_ce  output  1  drives CE of all IDDRs.
rxd_q1  input  4  IDDR Q1 data, rising-edge nibble (byte bits 3:0).
rxd_q2  input  4  IDDR Q2 data, falling-edge nibble (byte bits 7:4).
ctl_q1  input  1  control IDDR Q1 = RX_DV.
ctl_q2  input  1  control IDDR Q2 = RX_DV xor RX_ER.
src_valid  output  1  byte valid.
src_data  output  8  payload byte.
src_first  output  1  first byte after SFD.
src_last  output  1  final byte of frame.
src_error  output  1  frame error, qualified with src_last.
frames_ok  output  CNT_W  saturating count of good frames.
frames_err  output  CNT_W  saturating count of errored frames.
link_up  output  1  in-band link status.
link_speed  output  2  in-band speed: 0=10M, 1=100M, 2=1G.
full_duplex  output  1  in-band duplex.

Behaviour:
- Clock and reset: one clock C; reset R is asynchronous, active-high.
- Reset values: iddr_rst=1, iddr_ce=0, all src_* outputs 0, counters 0, status outputs 0. State resets to INIT.
- Per-cycle decode:
  - byte = {rxd_q2, rxd_q1}.
  - dv = ctl_q1.
  - er = ctl_q1 ^ ctl_q2.
- State machine:
  - INIT: counts IDDR_RST_CYCLES cycles with iddr_rst=1, then iddr_rst=0 and iddr_ce=1 (CE stays high from then on). Next state SETTLE.
  - SETTLE: 2 cycles for the IDDR pipeline to fill, then IDLE.
  - IDLE: on dv=1 and byte==0x55, preamble count=1 and go to PREAMBLE. On dv=1 with any other byte, go to DROP.
  - PREAMBLE:
    - dv=1, byte==0x55: count++. If count exceeds MAX_PREAMBLE, go to DROP.
    - dv=1, byte==0xD5: if count>=MIN_PREAMBLE go to DATA, else go to DROP.
    - Any other byte, or dv=0: go to IDLE. Nothing is emitted.
  - DATA: each byte with dv=1 is loaded into a one-byte hold register. The byte already held is emitted in the same cycle.
    - On dv 1->0, the held byte is emitted with src_last=1. Then IDLE.
    - If the length counter exceeds MAX_FRAME_LEN, the held byte is emitted with src_last=1 and src_error=1. Then DROP.
  - DROP: ignores bytes until dv=0, then IDLE. Nothing is emitted.
- Latency: a payload byte appears on src_data 2 C cycles after it appears on rxd_q1/q2.
- Output flags:
  - src_first is set on the first emitted byte of each frame.
  - A one-byte frame emits a single beat with src_first=1 and src_last=1.
  - src_valid is a single-cycle pulse per byte. There is no backpressure; the consumer must accept every beat.
- Errors: er=1 on any DATA byte sets a sticky frame-error flag, reported as src_error on the last beat.
- Counters: on each last beat, frames_err increments if src_error=1, otherwise frames_ok increments. Both saturate at all-ones.
- R asserted mid-frame: all outputs return to reset values asynchronously, no last beat is emitted, and the IDDR reset sequence restarts.
- dv=0 in SFD position (PREAMBLE state): returns to IDLE, no output.

Optional Feature:
RGMII_INBAND_STATUS_EN:
- Defined: while in IDLE with dv=0 and er=0, rxd_q1 is decoded each cycle as follows, with registered outputs updated on every such cycle:
  - bit0 -> link_up.
  - bits2:1 -> link_speed.
  - bit3 -> full_duplex.
- Undefined: link_up, link_speed and full_duplex are held at constant 0 and no decode logic is built.

Test Plan:
- Reset sequencing: release R at cycle 0 -> iddr_rst high for exactly 8 cycles, iddr_ce rises with the iddr_rst fall, no src_valid during SETTLE.
- Frame: 7x 0x55, 0xD5, then payload 0x01..0x40 (64 bytes) -> 64 beats, src_data 0x01 at first beat with src_first=1 (2 cycles after the first payload byte at the inputs), src_last at 0x40, src_error=0, frames_ok=1.
- Errored frame: 8-byte payload with er=1 on byte 3 -> 8 beats, src_last with src_error=1, frames_err=1, frames_ok unchanged.
- Bad preamble: 1x 0x55 then 0xD5 (MIN_PREAMBLE=2) -> no beats, counters unchanged. Next valid frame received normally.
- Oversize: MAX_FRAME_LEN=16, 20-byte payload -> exactly 16 beats, last one has src_last=1 and src_error=1, remaining bytes dropped, frames_err=1.
- Reset mid-frame: assert R after 5 payload beats -> outputs 0 immediately, no src_last, iddr_rst high again for 8 cycles.
